// File: rtl/alu_unit.sv
// alu_unit -- 32-bit integer ALU with registered result and status flags.
//
// Combines operands A and B according to a 4-bit operation select. Result,
// sign, carry and zero are all registered, so they appear one clock after the
// inputs are presented. One operation per cycle; there is no valid/ready
// handshake and no stall -- every rising edge with rst low captures whatever
// A/B/Sel combination is present at that moment.
//
// Ports:
//   clk     in   1      system clock, rising-edge active
//   rst     in   1      asynchronous, active-high reset (clears all outputs)
//   A       in   WIDTH  value operand (add / complement / logic / shift)
//   B       in   WIDTH  addend, logic operand, or shift amount in B[4:0]
//   Sel     in   4      operation select (0 ADD, 1 COMP, 2 AND, 3 XOR,
//                       4 SLL, 5 SRL, 6 SRA, 7-15 reserved -> 0)
//   result  out  WIDTH  registered operation result
//   sign    out  1      registered result MSB
//   carry   out  1      registered carry / last-shifted-out bit
//   zero    out  1      registered (result == 0)

module alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Sel,
  output logic [WIDTH-1:0] result,
  output logic             sign,
  output logic             carry,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_COMP = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;

  logic [SHW-1:0]          sh;
  logic [WIDTH:0]          sum_w;
  logic [WIDTH:0]          neg_w;
  logic [WIDTH:0]          shl_w;
  logic [WIDTH:0]          shr_w;
  logic signed [WIDTH:0]   sra_w;

  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d,  carry_q;
  logic             sign_d,   sign_q;
  logic             zero_d,   zero_q;

  assign sh = B[SHW-1:0];

  // One extra bit on every datapath catches the carry or the last bit shifted
  // out. For left shifts it lands in bit WIDTH (A[WIDTH-sh]); for right
  // shifts a guard bit below the LSB ends up in bit 0 (A[sh-1]). With sh=0
  // both of those extra bits are the zero padding, which gives carry=0.
  assign sum_w = {1'b0, A} + {1'b0, B};
  assign neg_w = {1'b0, ~A} + {{WIDTH{1'b0}}, 1'b1};
  assign shl_w = {1'b0, A} << sh;
  assign shr_w = {A, 1'b0} >> sh;
  assign sra_w = $signed({A, 1'b0}) >>> sh;

  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    case (Sel)
      OP_ADD: begin
        result_d = sum_w[WIDTH-1:0];
        carry_d  = sum_w[WIDTH];
      end
      OP_COMP: begin
        result_d = neg_w[WIDTH-1:0];
        carry_d  = neg_w[WIDTH];
      end
      OP_AND: result_d = A & B;
      OP_XOR: result_d = A ^ B;
      OP_SLL: begin
        result_d = shl_w[WIDTH-1:0];
        carry_d  = shl_w[WIDTH];
      end
      OP_SRL: begin
        result_d = shr_w[WIDTH:1];
        carry_d  = shr_w[0];
      end
      OP_SRA: begin
        result_d = sra_w[WIDTH:1];
        carry_d  = sra_w[0];
      end
      default: begin
        result_d = '0;
        carry_d  = 1'b0;
      end
    endcase
    // Flags are derived from the next result so they line up with it; zero is
    // its own flop because it must read 0 (not 1) while reset is held.
    sign_d = result_d[WIDTH-1];
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign sign   = sign_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit -- directed-vector bench for alu_unit.
// Each test task drives its own table of operands and compares the packed
// observation {result, carry, sign, zero} against hand-computed values.

module tb_alu_unit;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  Sel;
  logic [31:0] result;
  logic        sign;
  logic        carry;
  logic        zero;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .Sel    (Sel),
    .result (result),
    .sign   (sign),
    .carry  (carry),
    .zero   (zero)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    @(negedge clk);
    A   = a;
    B   = b;
    Sel = s;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [34:0] obs;
    // Outputs while rst is held from time zero.
    #2;
    obs = {result, carry, sign, zero};
    n_cmp++;
    if (obs !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_initial: got %h, want %h", obs, 35'd0);
    end
    // A live op under reset must not load across a clock edge.
    drive(32'h0000_0005, 32'h0000_0003, 4'd0);
    @(posedge clk); #1;
    obs = {result, carry, sign, zero};
    n_cmp++;
    if (obs !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h, want %h", obs, 35'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    obs = {result, carry, sign, zero};
    n_cmp++;
    if (obs !== {32'h0000_0008, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release: got %h, want %h", obs, {32'h0000_0008, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_add();
    logic [31:0] va [4] = '{32'hC465_4BAE, 32'h000F_4257, 32'h8919_A3E0, 32'hFFFF_FFFF};
    logic [31:0] vb [4] = '{32'h3B9A_CF1D, 32'h0000_000C, 32'h8919_A3E0, 32'h0000_0001};
    // {result, carry, sign, zero}
    logic [34:0] ve [4] = '{{32'h0000_1ACB, 1'b1, 1'b0, 1'b0},
                            {32'h000F_4263, 1'b0, 1'b0, 1'b0},
                            {32'h1233_47C0, 1'b1, 1'b0, 1'b0},
                            {32'h0000_0000, 1'b1, 1'b0, 1'b1}};
    logic [34:0] obs;
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], 4'd0);
      @(posedge clk); #1;
      obs = {result, carry, sign, zero};
      n_cmp++;
      if (obs !== ve[i]) begin
        n_fail++;
        $display("FAIL add[%0d]: got res=%h c=%b s=%b z=%b, want res=%h c=%b s=%b z=%b",
                 i, obs[34:3], obs[2], obs[1], obs[0], ve[i][34:3], ve[i][2], ve[i][1], ve[i][0]);
      end
    end
  endtask

  task automatic test_comp();
    logic [31:0] va [3] = '{32'h0000_0000, 32'h0000_0005, 32'h8000_0000};
    logic [34:0] ve [3] = '{{32'h0000_0000, 1'b1, 1'b0, 1'b1},
                            {32'hFFFF_FFFB, 1'b0, 1'b1, 1'b0},
                            {32'h8000_0000, 1'b0, 1'b1, 1'b0}};
    logic [34:0] obs;
    for (int i = 0; i < 3; i++) begin
      drive(va[i], 32'h001E_8480, 4'd1);
      @(posedge clk); #1;
      obs = {result, carry, sign, zero};
      n_cmp++;
      if (obs !== ve[i]) begin
        n_fail++;
        $display("FAIL comp[%0d]: got res=%h c=%b s=%b z=%b, want res=%h c=%b s=%b z=%b",
                 i, obs[34:3], obs[2], obs[1], obs[0], ve[i][34:3], ve[i][2], ve[i][1], ve[i][0]);
      end
    end
  endtask

  task automatic test_logic();
    logic [31:0] va [3] = '{32'h8919_A3E0, 32'h8919_A3E0, 32'hF0F0_F0F0};
    logic [31:0] vb [3] = '{32'h8919_A3E0, 32'h8919_A3E0, 32'h0FF0_0FF0};
    logic [3:0]  vs [3] = '{4'd2, 4'd3, 4'd2};
    logic [34:0] ve [3] = '{{32'h8919_A3E0, 1'b0, 1'b1, 1'b0},
                            {32'h0000_0000, 1'b0, 1'b0, 1'b1},
                            {32'h00F0_00F0, 1'b0, 1'b0, 1'b0}};
    logic [34:0] obs;
    for (int i = 0; i < 3; i++) begin
      drive(va[i], vb[i], vs[i]);
      @(posedge clk); #1;
      obs = {result, carry, sign, zero};
      n_cmp++;
      if (obs !== ve[i]) begin
        n_fail++;
        $display("FAIL logic[%0d]: got res=%h c=%b s=%b z=%b, want res=%h c=%b s=%b z=%b",
                 i, obs[34:3], obs[2], obs[1], obs[0], ve[i][34:3], ve[i][2], ve[i][1], ve[i][0]);
      end
    end
  endtask

  task automatic test_shift();
    logic [31:0] va [12] = '{32'h000F_4257, 32'h000F_4257,
                             32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                             32'h8000_0000, 32'h8000_0000,
                             32'h8000_0001, 32'h8000_0001, 32'h8000_0001,
                             32'h0000_0003, 32'hDEAD_BEEF};
    logic [31:0] vb [12] = '{32'h0000_000C, 32'h0000_000C,
                             32'h001E_8480, 32'h001E_8480, 32'h001E_8480,
                             32'h0000_0004, 32'h0000_0004,
                             32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                             32'h0000_001F, 32'hFFFF_FFE0};
    logic [3:0]  vs [12] = '{4'd4, 4'd5,
                             4'd4, 4'd5, 4'd6,
                             4'd6, 4'd5,
                             4'd4, 4'd5, 4'd6,
                             4'd4, 4'd6};
    logic [34:0] ve [12] = '{{32'hF425_7000, 1'b0, 1'b1, 1'b0},
                             {32'h0000_00F4, 1'b0, 1'b0, 1'b0},
                             {32'h0000_0000, 1'b0, 1'b0, 1'b1},
                             {32'h0000_0000, 1'b0, 1'b0, 1'b1},
                             {32'h0000_0000, 1'b0, 1'b0, 1'b1},
                             {32'hF800_0000, 1'b0, 1'b1, 1'b0},
                             {32'h0800_0000, 1'b0, 1'b0, 1'b0},
                             {32'h0000_0002, 1'b1, 1'b0, 1'b0},
                             {32'h4000_0000, 1'b1, 1'b0, 1'b0},
                             {32'hC000_0000, 1'b1, 1'b1, 1'b0},
                             {32'h8000_0000, 1'b1, 1'b1, 1'b0},
                             // sh = 0 from B[4:0]: value passes through, carry 0
                             {32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0}};
    logic [34:0] obs;
    for (int i = 0; i < 12; i++) begin
      drive(va[i], vb[i], vs[i]);
      @(posedge clk); #1;
      obs = {result, carry, sign, zero};
      n_cmp++;
      if (obs !== ve[i]) begin
        n_fail++;
        $display("FAIL shift[%0d]: got res=%h c=%b s=%b z=%b, want res=%h c=%b s=%b z=%b",
                 i, obs[34:3], obs[2], obs[1], obs[0], ve[i][34:3], ve[i][2], ve[i][1], ve[i][0]);
      end
    end
  endtask

  task automatic test_reserved();
    logic [31:0] va [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [31:0] vb [3] = '{32'h0000_0004, 32'hFFFF_FFFF, 32'h0000_0003};
    logic [3:0]  vs [3] = '{4'd9, 4'd7, 4'd15};
    logic [34:0] exp_v = {32'h0000_0000, 1'b0, 1'b0, 1'b1};
    logic [34:0] obs;
    for (int i = 0; i < 3; i++) begin
      drive(va[i], vb[i], vs[i]);
      @(posedge clk); #1;
      obs = {result, carry, sign, zero};
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reserved[%0d]: got res=%h c=%b s=%b z=%b, want res=%h c=%b s=%b z=%b",
                 i, obs[34:3], obs[2], obs[1], obs[0], exp_v[34:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [34:0] obs;
    drive(32'h0000_0010, 32'h0000_0020, 4'd0);
    @(posedge clk); #1;
    obs = {result, carry, sign, zero};
    n_cmp++;
    if (obs !== {32'h0000_0030, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_before: got %h, want %h", obs, {32'h0000_0030, 1'b0, 1'b0, 1'b0});
    end
    // Assert reset between edges; outputs must clear without waiting for clk.
    #2;
    rst = 1'b1;
    #1;
    obs = {result, carry, sign, zero};
    n_cmp++;
    if (obs !== 35'd0) begin
      n_fail++;
      $display("FAIL mid_async_clear: got %h, want %h", obs, 35'd0);
    end
    drive(32'hFFFF_FFFF, 32'h0000_0004, 4'd0);
    @(posedge clk); #1;
    obs = {result, carry, sign, zero};
    n_cmp++;
    if (obs !== 35'd0) begin
      n_fail++;
      $display("FAIL mid_hold: got %h, want %h", obs, 35'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    obs = {result, carry, sign, zero};
    n_cmp++;
    if (obs !== {32'h0000_0003, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_release: got %h, want %h", obs, {32'h0000_0003, 1'b1, 1'b0, 1'b0});
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    A   = '0;
    B   = '0;
    Sel = '0;
    test_reset();
    test_add();
    test_comp();
    test_logic();
    test_shift();
    test_reserved();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
